sha256_wsched: RTL and testbench
================================

SHA256_WSCHED -- requirements
Module: sha256_wsched

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h800, giving the 128-word-aligned base of the memory-mapped window on the data-memory bus.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low; sampled on rising edge of clock.
REQ-004 SHALL have port wren, input, 1, processor data-memory write enable.
REQ-005 SHALL have port address_dmem, input, 12, processor word address.
REQ-006 SHALL have port data, input, 32, processor write data.
REQ-007 SHALL have port q_wsched, output, 32, read data for the processor's data-memory read mux.
REQ-008 SHALL have port sel, output, 1, combinational: high when address_dmem[11:7] == BASE_ADDR[11:7].

Function
REQ-009 SHALL decode window offset off = address_dmem[6:0]: 0x00-0x3F are W[0..63]; 0x40 is CTRL (write-only); 0x41 is STATUS (read-only, {30'b0, done, busy}).
REQ-010 SHALL treat a bus write as occurring only when sel and wren are both high.
REQ-011 SHALL, in IDLE or DONE, store data into W[off] on a write to off 0x00-0x0F; writes to 0x10-0x3F SHALL be ignored in every state.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on a write to CTRL with data[0]=1; RUN->DONE after the cycle computing W[63]; DONE->RUN on a CTRL start; DONE->IDLE on a write to W[0..15].
REQ-013 SHALL, in RUN, compute one word per cycle for t = 16..63: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32.
REQ-014 SHALL use sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3 and sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-015 SHALL take exactly 48 cycles in RUN: the CTRL write at edge N enters RUN; W[16] is written at edge N+1; W[63] is written at edge N+48; done = 1 from edge N+48.
REQ-016 SHALL ignore W writes and CTRL writes while in RUN; busy = 1 only in RUN.
REQ-017 SHALL register q_wsched with one-cycle read latency: the value addressed at edge N appears after edge N; it is 0 when sel was low or off is 0x40 or 0x42-0x7F.
REQ-018 SHALL return the current contents of W[off] during RUN, including partially computed words.

Reset
REQ-019 SHALL, when reset is low at a rising edge, force IDLE, busy = 0, done = 0, the step counter to 16, and q_wsched = 0; W contents are not reset.
REQ-020 SHALL, on reset asserted mid-RUN, abort immediately; words already written remain, and the remaining words are not computed.

Configuration
REQ-021 SHALL, with macro WSCHED_IRQ_EN defined, add output port irq, 1 bit, pulsing high for exactly one cycle on each RUN->DONE transition, and 0 during and after reset.
REQ-022 SHALL, without WSCHED_IRQ_EN, omit the irq port entirely, with no other behavioural change.

Structure
REQ-023 SHALL place the offset constants (W_LAST=0x3F, CTRL=0x40, STATUS=0x41), the FSM state encoding, and the round count 48 in shared package sha256_pkg.
REQ-024 SHALL place sigma0/sigma1 in combinational sub-module sha256_sigma, reusable by the compression stage.

Verification
REQ-025 SHALL cover: write W0=0x61626380, W1..W14=0, W15=0x00000018, then CTRL=1 -> W[16] reads 0x61626380 and W[17] reads 0x000F0000; STATUS reads 0x2 after 48 cycles.
REQ-026 SHALL cover: all W[0..15]=0, then start -> W[16..63] all read 0, and done is asserted at exactly the 48th edge after the start write.
REQ-027 SHALL cover: during RUN, write W0=0xFFFFFFFF and a second CTRL start -> both ignored, W0 unchanged, and completion timing unchanged.
REQ-028 SHALL cover: reset low at cycle 10 of RUN -> STATUS reads 0x0, W[16..25] hold computed values, and W[26] retains its prior value.
REQ-029 SHALL cover: a write to off 0x20 -> ignored; a read with sel low or off 0x50 -> q_wsched = 0 the next cycle.
REQ-030 SHALL cover, with WSCHED_IRQ_EN: irq is high for exactly one cycle on RUN->DONE, and stays low when DONE is left by a W0 write.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message-schedule window and its
// compression-stage neighbours.
package sha256_pkg;

   // Window offsets, relative to the 128-word-aligned base
   localparam logic [6:0] OFF_W_LAST = 7'h3F;
   localparam logic [6:0] OFF_CTRL   = 7'h40;
   localparam logic [6:0] OFF_STATUS = 7'h41;

   localparam int unsigned ROUNDS = 48;

   // Step counter walks the computed words W[16..63]
   localparam logic [5:0] STEP_FIRST = 6'd16;
   localparam logic [5:0] STEP_LAST  = 6'(16 + ROUNDS - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma functions; purely combinational so the compression stage
// can share it.
module sha256_sigma (
   input  logic [31:0] x0,
   input  logic [31:0] x1,
   output logic [31:0] sigma0,
   output logic [31:0] sigma1
);

   // sigma0 = ROTR7 ^ ROTR18 ^ SHR3, sigma1 = ROTR17 ^ ROTR19 ^ SHR10
   assign sigma0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ {3'b000, x0[31:3]};
   assign sigma1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ {10'b0, x1[31:10]};

endmodule

// File: rtl/sha256_wsched.sv
// Memory-mapped SHA-256 message-schedule expander: W[0..15] written by the CPU,
// W[16..63] computed one per cycle. Define WSCHED_IRQ_EN to add the irq port.
module sha256_wsched
   import sha256_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = 12'h800
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wren,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   output logic [31:0] q_wsched,
   output logic        sel
`ifdef WSCHED_IRQ_EN
   ,
   output logic        irq
`endif
);

   logic [6:0]  off;
   logic        bus_wr;
   logic        host_w_wr;
   logic        ctrl_start;

   state_e      state_q, state_d;
   logic [5:0]  step_q, step_d;
   logic        run_last;
   logic        busy, done;

   logic [31:0] w_mem [64];
   logic        w_we;
   logic [5:0]  w_wa;
   logic [31:0] w_wd;
   logic [31:0] w_new;
   logic [31:0] sig0, sig1;

   logic [31:0] rd_d, rd_q;

   assign off        = address_dmem[6:0];
   assign sel        = (address_dmem[11:7] == BASE_ADDR[11:7]);
   assign bus_wr     = sel & wren;
   assign host_w_wr  = bus_wr && (off <= 7'h0F);
   assign ctrl_start = bus_wr && (off == OFF_CTRL) && data[0];

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign run_last = busy && (step_q == STEP_LAST);

   sha256_sigma u_sigma (
      .x0     (w_mem[step_q - 6'd15]),
      .x1     (w_mem[step_q - 6'd2]),
      .sigma0 (sig0),
      .sigma1 (sig1)
   );

   assign w_new = sig1 + w_mem[step_q - 6'd7] + sig0 + w_mem[step_q - 6'd16];

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      w_we    = 1'b0;
      w_wa    = off[5:0];
      w_wd    = data;
      case (state_q)
         StIdle: begin
            if (ctrl_start) begin
               state_d = StRun;
               step_d  = STEP_FIRST;
            end else if (host_w_wr) begin
               w_we = 1'b1;
            end
         end
         StRun: begin
            // Bus writes are locked out; the datapath owns the write port
            w_we = 1'b1;
            w_wa = step_q;
            w_wd = w_new;
            if (run_last) begin
               state_d = StDone;
               step_d  = STEP_FIRST;
            end else begin
               step_d = step_q + 6'd1;
            end
         end
         StDone: begin
            if (ctrl_start) begin
               state_d = StRun;
               step_d  = STEP_FIRST;
            end else if (host_w_wr) begin
               w_we    = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            step_d  = STEP_FIRST;
         end
      endcase
   end

   always_comb begin
      rd_d = '0;
      if (sel) begin
         if (off <= OFF_W_LAST) begin
            rd_d = w_mem[off[5:0]];
         end else if (off == OFF_STATUS) begin
            rd_d = {30'b0, done, busy};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         step_q  <= STEP_FIRST;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rd_q    <= rd_d;
      end
   end

   // Word storage is not reset; reset only blocks the write so a run aborts cleanly
   always_ff @(posedge clock) begin
      if (reset && w_we) begin
         w_mem[w_wa] <= w_wd;
      end
   end

   assign q_wsched = rd_q;

`ifdef WSCHED_IRQ_EN
   logic irq_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= run_last;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sha256_wsched.sv
// Directed bench for sha256_wsched: table-driven reads plus hand-written
// sequences for run timing, lockout, window decode and mid-run reset.
module tb_sha256_wsched;

   localparam logic [11:0] BASE = 12'h800;

   logic        clock = 1'b0;
   logic        reset;
   logic        wren;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic [31:0] q_wsched;
   logic        sel;
`ifdef WSCHED_IRQ_EN
   logic        irq;
`endif

   sha256_wsched #(
      .BASE_ADDR (BASE)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .wren         (wren),
      .address_dmem (address_dmem),
      .data         (data),
      .q_wsched     (q_wsched),
      .sel          (sel)
`ifdef WSCHED_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0]  off;
      logic [31:0] exp;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] msg   [16];
   logic [31:0] ref_w [64];
   vec_t        tbl   [9];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic compute_ref();
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
         s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
         ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [6:0] off, input logic [31:0] d);
      address_dmem = BASE | {5'b0, off};
      data         = d;
      wren         = 1'b1;
      tick();
      wren         = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] addr, output logic [31:0] v);
      address_dmem = addr;
      wren         = 1'b0;
      tick();
      v = q_wsched;
   endtask

   task automatic load_msg();
      for (int i = 0; i < 16; i++) bus_write(7'(i), msg[i]);
   endtask

   // Start a run and watch STATUS: busy must still read back after edge N+48,
   // done only after N+49 (one-cycle read latency). Optional writes mid-run.
   task automatic run_and_time(input bit inject, input string tag);
      bus_write(7'h40, 32'h1);
      for (int k = 1; k <= 49; k++) begin
         if (inject && k == 5) begin
            address_dmem = BASE;
            data         = 32'hFFFF_FFFF;
            wren         = 1'b1;
         end else if (inject && k == 6) begin
            address_dmem = BASE | 12'h040;
            data         = 32'h1;
            wren         = 1'b1;
         end else begin
            address_dmem = BASE | 12'h041;
            wren         = 1'b0;
         end
         tick();
         wren = 1'b0;
         if (k == 48) check($sformatf("%s status k48", tag), q_wsched, 32'h1);
         if (k == 49) check($sformatf("%s status k49", tag), q_wsched, 32'h2);
`ifdef WSCHED_IRQ_EN
         if (k >= 47) check($sformatf("%s irq k%0d", tag, k), {31'b0, irq}, {31'b0, k == 48});
`endif
      end
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] old_w26;

      reset        = 1'b0;
      wren         = 1'b0;
      address_dmem = '0;
      data         = '0;
      tick();
      tick();
      check("reset q", q_wsched, 32'h0);
`ifdef WSCHED_IRQ_EN
      check("reset irq", {31'b0, irq}, 32'h0);
`endif
      reset = 1'b1;
      bus_read(BASE | 12'h041, v);
      check("reset status", v, 32'h0);

      // All-zero message: every computed word is zero
      for (int i = 0; i < 16; i++) msg[i] = '0;
      load_msg();
      run_and_time(1'b0, "zero");
      for (int t = 16; t < 64; t++) begin
         bus_read(BASE | 12'(t), v);
         check($sformatf("zero W%0d", t), v, 32'h0);
      end

      // "abc" padded block, with ignored writes injected mid-run
      for (int i = 0; i < 16; i++) msg[i] = '0;
      msg[0]  = 32'h6162_6380;
      msg[15] = 32'h0000_0018;
      compute_ref();
      load_msg();
      run_and_time(1'b1, "abc");

      tbl[0] = '{7'h00, 32'h6162_6380};
      tbl[1] = '{7'h0F, 32'h0000_0018};
      tbl[2] = '{7'h10, 32'h6162_6380};
      tbl[3] = '{7'h11, 32'h000F_0000};
      tbl[4] = '{7'h12, 32'h7DA8_6405};
      tbl[5] = '{7'h13, 32'h6000_03C6};
      tbl[6] = '{7'h41, 32'h0000_0002};
      tbl[7] = '{7'h40, 32'h0000_0000};
      tbl[8] = '{7'h50, 32'h0000_0000};
      for (int i = 0; i < 9; i++) begin
         bus_read(BASE | {5'b0, tbl[i].off}, v);
         check($sformatf("abc off 0x%02h", tbl[i].off), v, tbl[i].exp);
      end
      for (int t = 20; t < 64; t++) begin
         bus_read(BASE | 12'(t), v);
         check($sformatf("abc W%0d", t), v, ref_w[t]);
      end

      // Window decode: computed-range write ignored, out-of-window reads return 0
      bus_write(7'h20, 32'hDEAD_BEEF);
      bus_read(BASE | 12'h020, v);
      check("write 0x20 ignored", v, ref_w[32]);
      bus_read(BASE | 12'h041, v);
      check("done kept after 0x20 write", v, 32'h2);
      address_dmem = 12'h000;
      #1;
      check("sel low", {31'b0, sel}, 32'h0);
      bus_read(12'h000, v);
      check("sel low read", v, 32'h0);
      bus_read(12'h880, v);
      check("next window read", v, 32'h0);
      address_dmem = BASE | 12'h041;
      #1;
      check("sel high", {31'b0, sel}, 32'h1);

      // Leave DONE via a W0 write (no irq), then reset at cycle 10 of a run
      old_w26 = ref_w[26];
      for (int i = 0; i < 16; i++) msg[i] = 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101);
      compute_ref();
      bus_write(7'h00, msg[0]);
`ifdef WSCHED_IRQ_EN
      check("irq on W0 exit", {31'b0, irq}, 32'h0);
`endif
      bus_read(BASE | 12'h041, v);
      check("idle after W0 write", v, 32'h0);
`ifdef WSCHED_IRQ_EN
      check("irq stays low", {31'b0, irq}, 32'h0);
`endif
      load_msg();
      bus_write(7'h40, 32'h1);
      address_dmem = BASE | 12'h041;
      for (int k = 1; k <= 10; k++) tick();
      reset = 1'b0;
      tick();
      check("midrun reset q", q_wsched, 32'h0);
      reset = 1'b1;
      bus_read(BASE | 12'h041, v);
      check("midrun reset status", v, 32'h0);
      for (int t = 16; t < 26; t++) begin
         bus_read(BASE | 12'(t), v);
         check($sformatf("abort W%0d", t), v, ref_w[t]);
      end
      bus_read(BASE | 12'h01A, v);
      check("abort W26 retained", v, old_w26);
      tick();
      tick();
      bus_read(BASE | 12'h041, v);
      check("no restart after abort", v, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
